// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clocked-out frame, device ACK check.
// Optional build macro PS2_TX_RETRY_EN: retry a failed byte twice before reporting tx_error.
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int START_TO_US = 15000,
  parameter int BIT_TO_US   = 2000,
  parameter int FILT_LEN    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [2:0] dbg_state
);
  // Handshake: a byte is accepted on a cycle where tx_valid & tx_ready; tx_ready is high only in IDLE.
  localparam longint INHIBIT_CYC = longint'(INHIBIT_US)  * longint'(CLK_FREQ_HZ) / 1_000_000;
  localparam longint START_CYC   = longint'(START_TO_US) * longint'(CLK_FREQ_HZ) / 1_000_000;
  localparam longint BIT_CYC     = longint'(BIT_TO_US)   * longint'(CLK_FREQ_HZ) / 1_000_000;
  localparam longint MAX_A       = (INHIBIT_CYC > BIT_CYC) ? INHIBIT_CYC : BIT_CYC;
  localparam longint MAX_CYC     = (MAX_A > START_CYC) ? MAX_A : START_CYC;
  localparam int     TW          = $clog2(MAX_CYC);
  localparam logic [TW-1:0] INH_T    = TW'(INHIBIT_CYC);
  localparam logic [TW-1:0] START_M1 = TW'(START_CYC - 1);
  localparam logic [TW-1:0] BIT_M1   = TW'(BIT_CYC - 1);
  localparam int     FW          = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0] FILT_M1  = FW'(FILT_LEN - 1);
`ifdef PS2_TX_RETRY_EN
  localparam logic [1:0] MAX_RETRY = 2'd2;
`else
  localparam logic [1:0] MAX_RETRY = 2'd0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_REL, S_DONE, S_ERROR
  } state_t;

  state_t          r_state, w_state_next;
  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_clk_f, r_clk_f_d, r_dat_f;
  logic [FW-1:0]   r_clk_cnt, r_dat_cnt;
  logic [9:0]      r_frame;
  logic [3:0]      r_bit_cnt;
  logic            r_data_drv;
  logic [TW-1:0]   r_timer;
  logic [1:0]      r_try;
  logic            w_fall, w_retry, w_reload;

  // Levels only change after FILT_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1 <= 1'b1; r_clk_s2 <= 1'b1; r_dat_s1 <= 1'b1; r_dat_s2 <= 1'b1;
      r_clk_f  <= 1'b1; r_clk_f_d <= 1'b1; r_dat_f <= 1'b1;
      r_clk_cnt <= '0; r_dat_cnt <= '0;
    end else begin
      r_clk_s1  <= ps2_clk_in;  r_clk_s2 <= r_clk_s1;
      r_dat_s1  <= ps2_data_in; r_dat_s2 <= r_dat_s1;
      r_clk_f_d <= r_clk_f;
      if (r_clk_s2 == r_clk_f) r_clk_cnt <= '0;
      else if (r_clk_cnt == FILT_M1) begin r_clk_f <= r_clk_s2; r_clk_cnt <= '0; end
      else r_clk_cnt <= r_clk_cnt + FW'(1);
      if (r_dat_s2 == r_dat_f) r_dat_cnt <= '0;
      else if (r_dat_cnt == FILT_M1) begin r_dat_f <= r_dat_s2; r_dat_cnt <= '0; end
      else r_dat_cnt <= r_dat_cnt + FW'(1);
    end
  end

  assign w_fall   = r_clk_f_d & ~r_clk_f;
  assign w_retry  = (r_try != MAX_RETRY);
  // Falls only restart the timer in the phases clocked by the device, so inhibit is never stretched.
  assign w_reload = (w_state_next != r_state) || (w_fall && (r_state == S_SHIFT || r_state == S_ACK));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (tx_valid) w_state_next = S_INHIBIT;
      S_INHIBIT:  if (r_timer == INH_T) w_state_next = S_RTS;
      S_RTS:      w_state_next = S_SHIFT;
      S_SHIFT: begin
        if (w_fall) begin
          if (r_bit_cnt == 4'd9) w_state_next = S_ACK;
        end else if (r_timer >= ((r_bit_cnt == 4'd0) ? START_M1 : BIT_M1)) begin
          w_state_next = S_ERROR;
        end
      end
      S_ACK: begin
        if (w_fall)                 w_state_next = r_dat_f ? S_ERROR : S_WAIT_REL;
        else if (r_timer >= BIT_M1) w_state_next = S_ERROR;
      end
      S_WAIT_REL: begin
        if (r_clk_f && r_dat_f)     w_state_next = S_DONE;
        else if (r_timer >= BIT_M1) w_state_next = S_ERROR;
      end
      S_DONE:     w_state_next = S_IDLE;
      S_ERROR:    w_state_next = w_retry ? S_INHIBIT : S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready    = (r_state == S_IDLE);
    busy        = (r_state != S_IDLE);
    tx_done     = (r_state == S_DONE);
    tx_error    = (r_state == S_ERROR) && !w_retry;
    ps2_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_RTS);
    ps2_data_oe = (r_state == S_RTS) || ((r_state == S_SHIFT) && r_data_drv);
    dbg_state   = r_state;
  end

  // The start bit is driven from RTS, so fall n places frame bit n-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame <= '0; r_bit_cnt <= '0; r_data_drv <= 1'b0; r_timer <= '0; r_try <= '0;
    end else begin
      if (w_reload)            r_timer <= TW'(1);
      else if (r_timer != '1)  r_timer <= r_timer + TW'(1);
      case (r_state)
        S_IDLE: if (tx_valid) begin
          r_frame <= {1'b1, ~^tx_data, tx_data};
          r_try   <= '0;
        end
        S_RTS: begin
          r_bit_cnt  <= '0;
          r_data_drv <= 1'b1;
        end
        S_SHIFT: if (w_fall) begin
          r_data_drv <= ~r_frame[r_bit_cnt];
          r_bit_cnt  <= r_bit_cnt + 4'd1;
        end
        S_ERROR: if (w_retry) r_try <= r_try + 2'd1;
        default: ;
      endcase
    end
  end
endmodule
